// File: rtl/world_map_arbiter.sv
// Shares the single-port world-map RAM between the fixed-latency video fetch and the bot port.
// Optional starvation guard is built when WORLD_MAP_ARB_STARVE_GUARD_EN is defined.
module world_map_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 2,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vidReq,
    input  logic [ADDR_W-1:0] vidAddr,
    output logic [DATA_W-1:0] vidData,
    output logic              vidValid,
    input  logic              botReq,
    input  logic              botWe,
    input  logic [ADDR_W-1:0] botAddr,
    input  logic [DATA_W-1:0] botWrData,
    output logic [DATA_W-1:0] botRdData,
    output logic              botAck,
    output logic [ADDR_W-1:0] ramAddr,
    output logic              ramWe,
    output logic [DATA_W-1:0] ramWrData,
    input  logic [DATA_W-1:0] ramRdData,
    output logic              starveErr
);
    localparam logic [1:0] B_IDLE = 2'd0;
    localparam logic [1:0] B_PEND = 2'd1;
    localparam logic [1:0] B_BUSY = 2'd2;
    localparam logic [1:0] B_DONE = 2'd3;

    // Bot handshake: botReq is a level held until botAck; botAck is a one-cycle pulse, and a
    // botReq still high after botAck must fall before the next request is accepted.
    logic [1:0]        bot_state_q, bot_state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wr_data_q, ram_wr_data_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_owner_q, s1_owner_d;
    logic              s2_valid_q, s2_owner_q;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] bot_rd_data_q, bot_rd_data_d;
    logic              bot_ack_q, bot_ack_d;
    logic              bot_grant;

    always_comb begin
        bot_grant = !vidReq &&
                    (((bot_state_q == B_IDLE) && botReq) || (bot_state_q == B_PEND));
    end

    always_comb begin
        bot_state_d = bot_state_q;
        case (bot_state_q)
            B_IDLE:  if (botReq) bot_state_d = vidReq ? B_PEND : B_BUSY;
            B_PEND:  if (!vidReq) bot_state_d = B_BUSY;
            B_BUSY:  if (bot_ack_q) bot_state_d = B_DONE;
            B_DONE:  if (!botReq) bot_state_d = B_IDLE;
            default: bot_state_d = B_IDLE;
        endcase
    end

    // Owner bit in the tag pipeline: 1 = bot read, 0 = video read.
    always_comb begin
        ram_addr_d    = ram_addr_q;
        ram_we_d      = 1'b0;
        ram_wr_data_d = ram_wr_data_q;
        if (vidReq) begin
            ram_addr_d = vidAddr;
        end else if (bot_grant) begin
            ram_addr_d    = botAddr;
            ram_we_d      = botWe;
            ram_wr_data_d = botWrData;
        end
        s1_valid_d = vidReq || (bot_grant && !botWe);
        s1_owner_d = !vidReq;

        vid_valid_d   = s2_valid_q && !s2_owner_q;
        vid_data_d    = vid_valid_d ? ramRdData : vid_data_q;
        bot_ack_d     = (bot_grant && botWe) || (s2_valid_q && s2_owner_q);
        bot_rd_data_d = (s2_valid_q && s2_owner_q) ? ramRdData : bot_rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bot_state_q   <= B_IDLE;
            ram_addr_q    <= '0;
            ram_we_q      <= 1'b0;
            ram_wr_data_q <= '0;
            s1_valid_q    <= 1'b0;
            s1_owner_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_owner_q    <= 1'b0;
            vid_data_q    <= '0;
            vid_valid_q   <= 1'b0;
            bot_rd_data_q <= '0;
            bot_ack_q     <= 1'b0;
        end else begin
            bot_state_q   <= bot_state_d;
            ram_addr_q    <= ram_addr_d;
            ram_we_q      <= ram_we_d;
            ram_wr_data_q <= ram_wr_data_d;
            s1_valid_q    <= s1_valid_d;
            s1_owner_q    <= s1_owner_d;
            s2_valid_q    <= s1_valid_q;
            s2_owner_q    <= s1_owner_q;
            vid_data_q    <= vid_data_d;
            vid_valid_q   <= vid_valid_d;
            bot_rd_data_q <= bot_rd_data_d;
            bot_ack_q     <= bot_ack_d;
        end
    end

`ifdef WORLD_MAP_ARB_STARVE_GUARD_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        starve_err_q, starve_err_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (bot_grant) begin
            wait_cnt_d = '0;
        end else if ((bot_state_q == B_PEND) && (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
        starve_err_d = starve_err_q || (wait_cnt_q >= 16'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q   <= '0;
            starve_err_q <= 1'b0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            starve_err_q <= starve_err_d;
        end
    end

    assign starveErr = starve_err_q;
`else
    logic [31:0] unused_starve_limit;
    assign unused_starve_limit = 32'(STARVE_LIMIT);
    assign starveErr = 1'b0;
`endif

    assign ramAddr   = ram_addr_q;
    assign ramWe     = ram_we_q;
    assign ramWrData = ram_wr_data_q;
    assign vidData   = vid_data_q;
    assign vidValid  = vid_valid_q;
    assign botRdData = bot_rd_data_q;
    assign botAck    = bot_ack_q;
endmodule
